// File: rtl/pc_sequencer_if.sv
// Request/status bundle between decode/branch-resolve (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             pc_en;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_offset;
    logic             jump;
    logic             call;
    logic [WIDTH-1:0] jump_target;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;
    logic             misalign;

    modport master (
        output pc_en, branch_taken, branch_offset, jump, call, jump_target, ret,
        input  pc_out, pc_next, stack_full, stack_empty, stack_err, misalign
    );

    modport slave (
        input  pc_en, branch_taken, branch_offset, jump, call, jump_target, ret,
        output pc_out, pc_next, stack_full, stack_empty, stack_err, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with increment, relative branch, absolute jump and a circular
// call/return stack. Define PC_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR.
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               INC          = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(4)
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        STK_NONE,
        STK_PUSH,
        STK_POP,
        STK_SWAP
    } stack_op_t;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PW-1:0]    top_q;
    logic [CW-1:0]    count_q;
    logic             err_q;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] top_entry;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] next_pc;
    logic             redirect;
    logic             err_set;
    logic             full;
    logic             empty;
    stack_op_t        stack_op;

    assign full      = (count_q == CW'(STACK_DEPTH));
    assign empty     = (count_q == '0);
    assign pc_inc    = pc_q + WIDTH'(INC);
    assign top_entry = stack_mem[top_q];

    always_comb begin
        raw_target = pc_inc;
        redirect   = 1'b0;
        err_set    = 1'b0;
        stack_op   = STK_NONE;
        if (bus.ret && bus.call) begin
            // Tail-call swap; with nothing to return to it degrades to a plain call.
            redirect = 1'b1;
            if (empty) begin
                raw_target = bus.jump_target;
                stack_op   = STK_PUSH;
            end else begin
                raw_target = top_entry;
                stack_op   = STK_SWAP;
            end
        end else if (bus.ret) begin
            if (empty) begin
                err_set = 1'b1;
            end else begin
                raw_target = top_entry;
                redirect   = 1'b1;
                stack_op   = STK_POP;
            end
        end else if (bus.call) begin
            raw_target = bus.jump_target;
            redirect   = 1'b1;
            stack_op   = STK_PUSH;
            err_set    = full;
        end else if (bus.jump) begin
            raw_target = bus.jump_target;
            redirect   = 1'b1;
        end else if (bus.branch_taken) begin
            raw_target = pc_q + bus.branch_offset;
            redirect   = 1'b1;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    logic misalign_q;

    assign misaligned = redirect && ((raw_target % WIDTH'(INC)) != '0);
    assign next_pc    = misaligned ? TRAP_VECTOR : raw_target;
    assign bus.misalign = misalign_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.pc_en && misaligned;
        end
    end
`else
    logic unused_trap;

    assign unused_trap  = ^TRAP_VECTOR;
    assign next_pc      = raw_target;
    assign bus.misalign = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.pc_en) begin
            pc_q  <= next_pc;
            err_q <= err_q | err_set;
            case (stack_op)
                STK_PUSH: begin
                    // When full the pointer walks onto the oldest slot, overwriting it.
                    top_q <= top_q + PW'(1);
                    if (!full) count_q <= count_q + CW'(1);
                end
                STK_POP: begin
                    top_q   <= top_q - PW'(1);
                    count_q <= count_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && bus.pc_en) begin
            case (stack_op)
                STK_PUSH: stack_mem[top_q + PW'(1)] <= pc_inc;
                STK_SWAP: stack_mem[top_q]          <= pc_inc;
                default: ;
            endcase
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.pc_next     = next_pc;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.stack_err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; expectations follow PC_MISALIGN_TRAP_EN when defined.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_sequencer_if #(.WIDTH(16)) bus ();

    pc_sequencer #(
        .WIDTH(16), .INC(2), .RESET_VECTOR(16'h0000),
        .STACK_DEPTH(8), .TRAP_VECTOR(16'h0004)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_RET  = 4'b1000;
    localparam logic [3:0] R_CALL = 4'b0100;
    localparam logic [3:0] R_JMP  = 4'b0010;
    localparam logic [3:0] R_BR   = 4'b0001;

    // flags are {full, empty, err, misalign}
    typedef struct {
        logic [15:0] pc;
        logic [3:0]  flags;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic stim_done = 1'b0;

    task automatic step(input logic r, input logic en, input logic [3:0] req,
                        input logic [15:0] tgt, input logic [15:0] off,
                        input logic [15:0] e_next, input logic [15:0] e_pc,
                        input logic [3:0] e_flags, input string nm);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.pc_en         = en;
        bus.ret           = req[3];
        bus.call          = req[2];
        bus.jump          = req[1];
        bus.branch_taken  = req[0];
        bus.jump_target   = tgt;
        bus.branch_offset = off;
        #1;
        if (!r) begin
            checks++;
            if (bus.pc_next !== e_next) begin
                errors++;
                $display("FAIL %s pc_next got %h expected %h", nm, bus.pc_next, e_next);
            end
        end
        e.pc = e_pc;
        e.flags = e_flags;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: the DUT presents a new registered state after every edge.
    initial begin
        exp_t e;
        logic [3:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {bus.stack_full, bus.stack_empty, bus.stack_err, bus.misalign};
                checks++;
                if (bus.pc_out !== e.pc) begin
                    errors++;
                    $display("FAIL %s pc_out got %h expected %h", e.name, bus.pc_out, e.pc);
                end
                checks++;
                if (got !== e.flags) begin
                    errors++;
                    $display("FAIL %s flags{full,empty,err,mis} got %b expected %b",
                             e.name, got, e.flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout stim_done got %b expected 1", stim_done);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] t;
        logic [15:0] mis_pc;
        logic [15:0] mis_after;
        logic        mis_flag;
        bus.pc_en = 1'b0; bus.ret = 1'b0; bus.call = 1'b0; bus.jump = 1'b0;
        bus.branch_taken = 1'b0; bus.jump_target = '0; bus.branch_offset = '0;

        step(1, 1, R_NONE, 16'h0, 16'h0, 16'h0, 16'h0000, 4'b0100, "reset");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h0002, 16'h0002, 4'b0100, "inc1");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h0004, 16'h0004, 4'b0100, "inc2");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h0006, 16'h0006, 4'b0100, "inc3");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h0008, 16'h0008, 4'b0100, "inc4");
        step(1, 1, R_JMP,  16'h0300, 16'h0, 16'h0, 16'h0000, 4'b0100, "reset_mid");

        step(0, 1, R_JMP, 16'h0010, 16'h0, 16'h0010, 16'h0010, 4'b0100, "jump_10");
        step(0, 1, R_BR,  16'h0, 16'hFFF8, 16'h0008, 16'h0008, 4'b0100, "branch_back");
        step(0, 1, R_JMP, 16'hFFFE, 16'h0, 16'hFFFE, 16'hFFFE, 4'b0100, "jump_fffe");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h0000, 16'h0000, 4'b0100, "inc_wrap");
        step(0, 0, R_JMP, 16'h0300, 16'h0, 16'h0300, 16'h0000, 4'b0100, "stall_jump");
        step(0, 0, R_CALL, 16'h0700, 16'h0, 16'h0700, 16'h0000, 4'b0100, "stall_call");
        step(0, 1, R_JMP | R_BR, 16'h0600, 16'h0004, 16'h0600, 16'h0600, 4'b0100, "jump_over_br");

        step(0, 1, R_JMP,  16'h0020, 16'h0, 16'h0020, 16'h0020, 4'b0100, "jump_20");
        step(0, 1, R_CALL, 16'h0100, 16'h0, 16'h0100, 16'h0100, 4'b0000, "call_100");
        step(0, 1, R_RET,  16'h0, 16'h0, 16'h0022, 16'h0022, 4'b0100, "ret_22");

        for (int k = 0; k < 9; k++) begin
            t = 16'(16'h1000 + k * 256);
            step(0, 1, R_CALL, t, 16'h0, t, t, {(k >= 7), 1'b0, (k == 8), 1'b0}, "nested_call");
        end
        for (int j = 0; j < 8; j++) begin
            t = 16'(16'h1702 - j * 256);
            step(0, 1, R_RET, 16'h0, 16'h0, t, t, {1'b0, (j == 7), 1'b1, 1'b0}, "nested_ret");
        end
        step(0, 1, R_RET, 16'h0, 16'h0, 16'h1004, 16'h1004, 4'b0110, "ret_underflow");
        step(0, 1, R_NONE, 16'h0, 16'h0, 16'h1006, 16'h1006, 4'b0110, "err_sticky");
        step(1, 1, R_NONE, 16'h0, 16'h0, 16'h0, 16'h0000, 4'b0100, "reset_clr_err");

        step(0, 1, R_JMP,  16'h003E, 16'h0, 16'h003E, 16'h003E, 4'b0100, "jump_3e");
        step(0, 1, R_CALL, 16'h0200, 16'h0, 16'h0200, 16'h0200, 4'b0000, "call_200");
        step(0, 1, R_RET | R_CALL | R_JMP | R_BR, 16'h0800, 16'h0010,
             16'h0040, 16'h0040, 4'b0000, "swap_all");
        step(0, 1, R_RET, 16'h0, 16'h0, 16'h0202, 16'h0202, 4'b0100, "ret_swapped");
        step(0, 1, R_RET | R_CALL, 16'h0500, 16'h0, 16'h0500, 16'h0500, 4'b0000, "swap_empty");
        step(0, 1, R_RET, 16'h0, 16'h0, 16'h0204, 16'h0204, 4'b0100, "ret_204");

`ifdef PC_MISALIGN_TRAP_EN
        mis_pc = 16'h0004; mis_after = 16'h0006; mis_flag = 1'b1;
`else
        mis_pc = 16'h0101; mis_after = 16'h0103; mis_flag = 1'b0;
`endif
        step(0, 1, R_JMP, 16'h0101, 16'h0, mis_pc, mis_pc, {3'b010, mis_flag}, "jump_odd");
        step(0, 1, R_NONE, 16'h0, 16'h0, mis_after, mis_after, 4'b0100, "after_odd");

        @(posedge clk);
        #2;
        stim_done = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
